// File: rtl/uadd_pkg.sv
// +------------------------------------------------------------------------+
// | uadd_pkg: shared types and helpers for the UADD/USUB datapath family    |
// | Rev 1.0 - initial release                                               |
// +------------------------------------------------------------------------+
`default_nettype none

package uadd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } usub_state_t;

  // Number of chunks an operand is split into.
  function automatic int unsigned usub_num_chunks(input int unsigned logwidth,
                                                  input int unsigned logchunk);
    return 32'd1 << (logwidth - logchunk);
  endfunction

endpackage

`default_nettype wire

// File: rtl/usub_chunk.sv
// +------------------------------------------------------------------------+
// | usub_chunk: combinational 2**LOGCHUNK-bit subtract with borrow in/out   |
// | Rev 1.0 - initial release                                               |
// +------------------------------------------------------------------------+
`default_nettype none

module usub_chunk #(
  parameter int LOGCHUNK = 3
) (
  input  logic [2**LOGCHUNK-1:0] i_a,
  input  logic [2**LOGCHUNK-1:0] i_b,
  input  logic                   i_bin,
  output logic [2**LOGCHUNK-1:0] o_d,
  output logic                   o_bout
);

  localparam int c_chunk = 2**LOGCHUNK;

  logic [c_chunk:0] w_diff;

  // The extra top bit goes to 1 exactly when the subtraction underflows.
  assign w_diff = {1'b0, i_a} - {1'b0, i_b} - {{c_chunk{1'b0}}, i_bin};
  assign o_d    = w_diff[c_chunk-1:0];
  assign o_bout = w_diff[c_chunk];

endmodule

`default_nettype wire

// File: rtl/usub_serial.sv
// +------------------------------------------------------------------------+
// | usub_serial: multi-cycle unsigned subtractor D = A - B - Bin, one chunk |
// | per clock, LSB chunk first. USUB_SIGNED_OVF_EN adds the o_vout port.    |
// | Rev 1.0 - initial release                                               |
// +------------------------------------------------------------------------+
`default_nettype none

module usub_serial
  import uadd_pkg::*;
#(
  parameter int LOGWIDTH = 5,
  parameter int LOGCHUNK = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic                   i_bin,
  input  logic [2**LOGWIDTH-1:0] i_a,
  input  logic [2**LOGWIDTH-1:0] i_b,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [2**LOGWIDTH-1:0] o_d,
  output logic                   o_bout
`ifdef USUB_SIGNED_OVF_EN
  ,
  output logic                   o_vout
`endif
);

  localparam int c_width  = 2**LOGWIDTH;
  localparam int c_chunk  = 2**LOGCHUNK;
  localparam int c_nchunk = int'(usub_num_chunks(LOGWIDTH, LOGCHUNK));
  localparam int c_kw     = (LOGWIDTH > LOGCHUNK) ? (LOGWIDTH - LOGCHUNK) : 1;
  localparam logic [c_kw-1:0] c_last_k = c_kw'(c_nchunk - 1);

  usub_state_t          r_state;
  logic [c_width-1:0]   r_a;
  logic [c_width-1:0]   r_b;
  logic                 r_bin;
  logic                 r_borrow;
  logic [c_kw-1:0]      r_k;
  logic [c_width-1:0]   r_d;
  logic                 r_bout;
  logic                 r_out_valid;
  logic                 r_vout;

  logic [c_chunk-1:0]   w_a_chunk;
  logic [c_chunk-1:0]   w_b_chunk;
  logic [c_chunk-1:0]   w_d_chunk;
  logic                 w_bin_chunk;
  logic                 w_bout_chunk;
  logic                 w_vout;

  assign w_a_chunk   = r_a[r_k*c_chunk +: c_chunk];
  assign w_b_chunk   = r_b[r_k*c_chunk +: c_chunk];
  assign w_bin_chunk = (r_k == '0) ? r_bin : r_borrow;

  usub_chunk #(
    .LOGCHUNK (LOGCHUNK)
  ) u_chunk (
    .i_a    (w_a_chunk),
    .i_b    (w_b_chunk),
    .i_bin  (w_bin_chunk),
    .o_d    (w_d_chunk),
    .o_bout (w_bout_chunk)
  );

  // Signed overflow: operands of differing sign and a result whose sign differs from A.
  assign w_vout = (r_a[c_width-1] ^ r_b[c_width-1]) & (w_d_chunk[c_chunk-1] ^ r_a[c_width-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_bin       <= 1'b0;
      r_borrow    <= 1'b0;
      r_k         <= '0;
      r_d         <= '0;
      r_bout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_vout      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_bin   <= i_bin;
            r_d     <= '0;
            r_k     <= '0;
            r_vout  <= 1'b0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_d[r_k*c_chunk +: c_chunk] <= w_d_chunk;
          r_borrow                    <= w_bout_chunk;
          if (r_k == c_last_k) begin
            r_bout      <= w_bout_chunk;
            r_vout      <= w_vout;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == IDLE) && rst_n;
  assign o_out_valid = r_out_valid;
  assign o_d         = r_d;
  assign o_bout      = r_bout;

`ifdef USUB_SIGNED_OVF_EN
  assign o_vout = r_vout;
`else
  logic w_unused;
  assign w_unused = r_vout;
`endif

endmodule

`default_nettype wire

// File: tb/tb_usub_serial.sv
// +------------------------------------------------------------------------+
// | tb_usub_serial: directed vector bench for usub_serial (W=32, C=8)      |
// | Rev 1.0 - initial release                                               |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_usub_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_in_valid;
  logic        o_in_ready;
  logic        i_bin;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [31:0] o_d;
  logic        o_bout;
`ifdef USUB_SIGNED_OVF_EN
  logic        o_vout;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  usub_serial #(
    .LOGWIDTH (5),
    .LOGCHUNK (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_bin       (i_bin),
    .i_a         (i_a),
    .i_b         (i_b),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_d         (o_d),
    .o_bout      (o_bout)
`ifdef USUB_SIGNED_OVF_EN
    ,
    .o_vout      (o_vout)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bout;
    logic        v;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                       output logic [31:0] d, output logic bout, output logic v,
                       output int lat);
    int w;
    w = 0;
    while (!o_in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (!o_in_ready) check("in_ready_timeout", 32'(o_in_ready), 32'd1);
    i_a = a; i_b = b; i_bin = bin; i_in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after acceptance: the result must depend only on latched operands.
    i_in_valid = 1'b0; i_a = $urandom; i_b = $urandom; i_bin = 1'($urandom_range(0, 1));
    lat = 0;
    while (!o_out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    d = o_d; bout = o_bout;
`ifdef USUB_SIGNED_OVF_EN
    v = o_vout;
`else
    v = 1'b0;
`endif
  endtask

  task automatic release_result();
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_out_ready = 1'b0;
    check("valid_drop", 32'(o_out_valid), 32'd0);
    check("ready_back", 32'(o_in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] d, hold_d;
    logic        bout, v;
    logic [32:0] s;
    logic [31:0] ra, rb;
    logic        rbin;
    int          lat;

    vecs[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0};
    vecs[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[2] = '{32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[3] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1};
    vecs[6] = '{32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0};
    vecs[7] = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[8] = '{32'hDEADBEEF, 32'h12345678, 1'b0, 32'hCC796877, 1'b0, 1'b0};
    vecs[9] = '{32'h00FF00FF, 32'h00FF0100, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};

    rst_n = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0;
    i_a = '0; i_b = '0; i_bin = 1'b0;
    #1;
    check("rst_out_valid", 32'(o_out_valid), 32'd0);
    check("rst_d", o_d, 32'd0);
    check("rst_bout", 32'(o_bout), 32'd0);
    check("rst_in_ready", 32'(o_in_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(o_in_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, d, bout, v, lat);
      check($sformatf("v%0d_d", i), d, vecs[i].d);
      check($sformatf("v%0d_bout", i), 32'(bout), 32'(vecs[i].bout));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
`ifdef USUB_SIGNED_OVF_EN
      check($sformatf("v%0d_vout", i), 32'(v), 32'(vecs[i].v));
`endif
      release_result();
    end

    // Backpressure: result held and no new accept while out_ready is low.
    do_op(32'h00000005, 32'h00000003, 1'b0, d, bout, v, lat);
    hold_d = d;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(o_out_valid), 32'd1);
      check("bp_d", o_d, hold_d);
      check("bp_bout", 32'(o_bout), 32'd0);
      check("bp_in_ready", 32'(o_in_ready), 32'd0);
    end
    release_result();

    // Reset mid-BUSY after two chunks have been written.
    i_a = 32'hFFFFFFFF; i_b = 32'h0; i_bin = 1'b0; i_in_valid = 1'b1;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("midbusy_partial_d", o_d, 32'h0000FFFF);
    rst_n = 1'b0;
    #1;
    check("mid_rst_d", o_d, 32'd0);
    check("mid_rst_bout", 32'(o_bout), 32'd0);
    check("mid_rst_valid", 32'(o_out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(o_in_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_release_ready", 32'(o_in_ready), 32'd1);
    check("mid_rst_release_valid", 32'(o_out_valid), 32'd0);
    do_op(32'h00000100, 32'h00000001, 1'b0, d, bout, v, lat);
    check("after_rst_d", d, 32'h000000FF);
    check("after_rst_bout", 32'(bout), 32'd0);
    release_result();

    // Random self-consistency: D + B + Bin == A (mod 2**32), Bout == (A < B + Bin).
    for (int r = 0; r < 8; r++) begin
      ra = $urandom; rb = $urandom; rbin = 1'($urandom_range(0, 1));
      do_op(ra, rb, rbin, d, bout, v, lat);
      s = {1'b0, d} + {1'b0, rb} + {32'd0, rbin};
      check("rand_identity", s[31:0], ra);
      check("rand_bout", 32'(bout), 32'({1'b0, ra} < ({1'b0, rb} + {32'd0, rbin})));
      release_result();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
